// File: rtl/i2s_tx.sv
// Stereo I2S transmitter: divides clk down to bclk, buffers one L/R pair and shifts
// it out MSB-first with one bclk of delay after each lrclk edge. Starved frames are zeros.
module i2s_tx #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SLOT_WIDTH = 32,
    parameter int unsigned BCLK_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] l_data,
    input  logic [DATA_WIDTH-1:0] r_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  bclk,
    output logic                  lrclk,
    output logic                  sdata,
    output logic                  underrun,
    output logic [15:0]           underrun_cnt
);
    localparam int unsigned FrameBits = 2 * SLOT_WIDTH;
    localparam int unsigned DivW      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int unsigned BitW      = $clog2(FrameBits);

    localparam logic [DivW-1:0] DivLast  = DivW'(BCLK_DIV - 1);
    localparam logic [BitW-1:0] BitLast  = BitW'(FrameBits - 1);
    localparam logic [BitW-1:0] SlotBits = BitW'(SLOT_WIDTH);

    logic [DivW-1:0]       div_q, div_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic [BitW-1:0]       bit_q, bit_d;
    logic [FrameBits-1:0]  shift_q, shift_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d;
    logic [DATA_WIDTH-1:0] hold_r_q, hold_r_d;
    logic                  underrun_q, underrun_d;
    logic [15:0]           ucnt_q, ucnt_d;

    logic                  div_wrap;
    logic                  shift_ev;
    logic                  frame_start;
    logic                  xfer;
    logic [BitW-1:0]       bit_nxt;
    logic [SLOT_WIDTH-1:0] l_slot;
    logic [SLOT_WIDTH-1:0] r_slot;

    always_comb begin
        div_wrap    = (div_q == DivLast);
        // Only the bclk 1->0 wrap advances data, so sdata is stable across rising bclk.
        shift_ev    = div_wrap && bclk_q;
        bit_nxt     = (bit_q == BitLast) ? '0 : bit_q + BitW'(1);
        frame_start = shift_ev && (bit_nxt == BitW'(1));
        xfer        = in_valid && !hold_full_q;

        l_slot = '0;
        r_slot = '0;
        l_slot[SLOT_WIDTH-1 -: DATA_WIDTH] = hold_l_q;
        r_slot[SLOT_WIDTH-1 -: DATA_WIDTH] = hold_r_q;
    end

    always_comb begin
        div_d       = div_wrap ? '0 : div_q + DivW'(1);
        bclk_d      = div_wrap ? ~bclk_q : bclk_q;
        bit_d       = shift_ev ? bit_nxt : bit_q;
        lrclk_d     = shift_ev ? (bit_nxt >= SlotBits) : lrclk_q;
        shift_d     = shift_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        underrun_d  = 1'b0;
        ucnt_d      = ucnt_q;

        if (frame_start) begin
            if (hold_full_q) begin
                shift_d     = {l_slot, r_slot};
                hold_full_d = 1'b0;
            end else begin
                shift_d    = '0;
                underrun_d = 1'b1;
                if (ucnt_q != 16'hFFFF) begin
                    ucnt_d = ucnt_q + 16'd1;
                end
            end
        end else if (shift_ev) begin
            shift_d = {shift_q[FrameBits-2:0], 1'b0};
        end

        // Capture needs an empty buffer before the edge, so it never races a frame load.
        if (xfer) begin
            hold_full_d = 1'b1;
            hold_l_d    = l_data;
            hold_r_d    = r_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            bit_q       <= '0;
            shift_q     <= '0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            underrun_q  <= 1'b0;
            ucnt_q      <= '0;
        end else begin
            div_q       <= div_d;
            bclk_q      <= bclk_d;
            lrclk_q     <= lrclk_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            underrun_q  <= underrun_d;
            ucnt_q      <= ucnt_d;
        end
    end

    assign in_ready     = !hold_full_q;
    assign bclk         = bclk_q;
    assign lrclk        = lrclk_q;
    assign sdata        = shift_q[FrameBits-1];
    assign underrun     = underrun_q;
    assign underrun_cnt = ucnt_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: time-based reference model checked every cycle, a bclk-sampling
// frame decoder, and directed scenarios with hand-computed expectations.
module tb_i2s_tx;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 32;
    localparam int unsigned BD = 2;
    localparam int unsigned FB = 2 * SW;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] l_data;
    logic [31:0] r_data;
    logic        in_valid;
    logic        in_ready;
    logic        bclk;
    logic        lrclk;
    logic        sdata;
    logic        underrun;
    logic [15:0] underrun_cnt;

    i2s_tx #(
        .DATA_WIDTH(DW),
        .SLOT_WIDTH(SW),
        .BCLK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .l_data      (l_data),
        .r_data      (r_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .bclk        (bclk),
        .lrclk       (lrclk),
        .sdata       (sdata),
        .underrun    (underrun),
        .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d)", name, act, exp, mt);
        end
    endtask

    // Reference model: everything follows from clk edges since reset release.
    int unsigned mt      = 0;
    logic [63:0] m_frame = '0;
    logic [63:0] m_hold  = '0;
    bit          m_pend  = 1'b0;
    bit          m_unr   = 1'b0;
    int unsigned m_cnt   = 0;
    bit          m_take;
    logic [63:0] m_sent[$];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mt      = 0;
            m_frame = '0;
            m_hold  = '0;
            m_pend  = 1'b0;
            m_unr   = 1'b0;
            m_cnt   = 0;
            m_sent.delete();
        end else begin
            m_take = in_valid && !m_pend;
            mt     = mt + 1;
            m_unr  = 1'b0;
            if ((mt % (2 * BD)) == 0 && ((mt / (2 * BD)) % FB) == 1) begin
                if (m_pend) begin
                    m_frame = m_hold;
                    m_pend  = 1'b0;
                end else begin
                    m_frame = '0;
                    m_unr   = 1'b1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
                m_sent.push_back(m_frame);
            end
            if (m_take) begin
                m_hold = {l_data, r_data};
                m_pend = 1'b1;
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    int unsigned e_bit;
    int unsigned e_idx;
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            e_bit = (mt / (2 * BD)) % FB;
            e_idx = (e_bit + FB - 1) % FB;
            chk("bclk", bclk, ((mt / BD) % 2) == 1);
            chk("lrclk", lrclk, e_bit >= SW);
            chk("sdata", sdata, m_frame[FB-1-e_idx]);
            chk("in_ready", in_ready, !m_pend);
            chk("underrun", underrun, m_unr);
            chk("underrun_cnt", underrun_cnt, m_cnt[15:0]);
        end
    end

    // Frame decoder: samples sdata/lrclk at each rising bclk, first slot bit = bit_cnt 1.
    logic        mon_prev = 1'b0;
    int          mon_r    = 0;
    int          mon_pos;
    int          mon_unr  = 0;
    logic [63:0] mon_d;
    logic [63:0] mon_l;
    logic [63:0] mon_frames[$];
    logic [63:0] mon_lrs[$];

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            mon_prev = 1'b0;
            mon_r    = 0;
            mon_unr  = 0;
            mon_frames.delete();
            mon_lrs.delete();
        end else begin
            if (bclk && !mon_prev) begin
                if (mon_r >= 1) begin
                    mon_pos = (mon_r - 1) % FB;
                    mon_d[FB-1-mon_pos] = sdata;
                    mon_l[FB-1-mon_pos] = lrclk;
                    if (mon_pos == FB - 1) begin
                        mon_frames.push_back(mon_d);
                        mon_lrs.push_back(mon_l);
                    end
                end
                mon_r++;
            end
            mon_prev = bclk;
            if (underrun) mon_unr++;
        end
    end

    function automatic logic [63:0] mon_frame(input int i);
        if (i < mon_frames.size()) return mon_frames[i];
        return {64{1'bx}};
    endfunction

    task automatic step_to(input int unsigned k);
        while (mt < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        l_data   = '0;
        r_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst bclk", bclk, 0);
        chk("rst lrclk", lrclk, 0);
        chk("rst sdata", sdata, 0);
        chk("rst in_ready", in_ready, 1);
        chk("rst underrun", underrun, 0);
        chk("rst underrun_cnt", underrun_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_pair(input logic [31:0] l, input logic [31:0] r);
        bit ok;
        bit rdy;
        ok       = 1'b0;
        l_data   = l;
        r_data   = r;
        in_valid = 1'b1;
        for (int i = 0; i < 700 && !ok; i++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
        end
        chk("pair accepted", ok, 1);
    endtask

    initial begin
        bit rdy;
        int n;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        l_data   = '0;
        r_data   = '0;
        #1;
        cmp_en = 1'b1;

        // Reset timing and single pair.
        do_reset();
        send_pair(32'h8000_0001, 32'h7FFF_FFFE);
        in_valid = 1'b0;
        step_to(2);
        chk("first rise bclk", bclk, 1);
        step_to(3);
        chk("bclk held", bclk, 1);
        step_to(4);
        chk("first fall bclk", bclk, 0);
        chk("first fall lrclk", lrclk, 0);
        step_to(259);
        chk("single no underrun", underrun_cnt, 0);
        step_to(512);
        chk("single frame data", mon_frame(0), {32'h8000_0001, 32'h7FFF_FFFE});
        chk("single frame lrclk", mon_lrs.size() > 0 ? mon_lrs[0] : {64{1'bx}},
            64'h0000_0001_FFFF_FFFE);

        // Back-to-back streaming.
        do_reset();
        for (int k = 1; k <= 10; k++) send_pair(32'(k), 32'(k + 256));
        in_valid = 1'b0;
        step_to(2563);
        chk("stream underrun_cnt", underrun_cnt, 0);
        step_to(2820);
        for (int k = 1; k <= 10; k++)
            chk("stream frame", mon_frame(k - 1), {32'(k), 32'(k + 256)});

        // Starvation after one pair.
        do_reset();
        send_pair(32'hDEAD_BEEF, 32'h0123_4567);
        in_valid = 1'b0;
        step_to(1020);
        chk("starve underrun_cnt", underrun_cnt, 3);
        chk("starve pulses", 64'(mon_unr), 3);
        step_to(1280);
        chk("starve frame1", mon_frame(0), {32'hDEAD_BEEF, 32'h0123_4567});
        for (int i = 1; i <= 3; i++) chk("starve zero frame", mon_frame(i), 0);

        // Collision: capture on the frame-start edge with an empty buffer.
        do_reset();
        step_to(3);
        l_data   = 32'hA5A5_0F0F;
        r_data   = 32'h3C3C_F00D;
        in_valid = 1'b1;
        step_to(4);
        in_valid = 1'b0;
        chk("collide captured", in_ready, 0);
        step_to(300);
        chk("collide underrun_cnt", underrun_cnt, 1);
        step_to(770);
        chk("collide frame1 zero", mon_frame(0), 0);
        chk("collide frame2", mon_frame(1), {32'hA5A5_0F0F, 32'h3C3C_F00D});

        // Randomised traffic, dense then sparse.
        do_reset();
        while (mt < 2100) begin
            if (!in_valid) begin
                if ($urandom_range(0, (mt < 1000) ? 29 : 399) == 0) begin
                    l_data   = $urandom;
                    r_data   = $urandom;
                    in_valid = 1'b1;
                end
            end
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (in_valid && rdy) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        chk("random frame count", mon_frames.size() >= 7, 1);
        n = (mon_frames.size() < m_sent.size()) ? mon_frames.size() : m_sent.size();
        for (int i = 0; i < n; i++) chk("random frame", mon_frames[i], m_sent[i]);

        // Reset mid-frame with a pair buffered.
        do_reset();
        send_pair(32'h1111_2222, 32'h3333_4444);
        send_pair(32'hCAFE_F00D, 32'hFEED_FACE);
        in_valid = 1'b0;
        chk("midrst buffered", in_ready, 0);
        step_to(160);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst bclk", bclk, 0);
        chk("midrst lrclk", lrclk, 0);
        chk("midrst sdata", sdata, 0);
        chk("midrst in_ready", in_ready, 1);
        chk("midrst underrun_cnt", underrun_cnt, 0);
        do_reset();
        step_to(3);
        chk("midrst cnt before frame", underrun_cnt, 0);
        step_to(4);
        chk("midrst first fall", bclk, 0);
        step_to(5);
        chk("midrst dropped pair", underrun_cnt, 1);
        step_to(512);
        chk("midrst frame zero", mon_frame(0), 0);

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
